// File: rtl/uart_program_loader.sv
// uart_program_loader: 8N1 UART boot loader assembling little-endian 32-bit words for memory port B.
// Optional idle-timeout early completion is enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_program_loader #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned WORD_COUNT   = 16384,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CLKS = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rx,
    output logic [31:0] UartData,
    output logic [31:0] UartAddress,
    output logic        UartWrite,
    output logic        UartOver,
    output logic        FrameError,
    output logic [15:0] WordsLoaded
);
    localparam int unsigned CPB = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          meta_q, rxs_q;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   shift_q, shift_d;
    logic [31:0]   data_q, data_d, addr_q, addr_d;
    logic          wr_q, wr_d, over_q, over_d, ferr_q, ferr_d;
    logic [15:0]   words_q, words_d;

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS);
    logic          rxp_q;
    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = (rxp_q && !rxs_q) ? '0 :
                 (st_q == IDLE && !over_q && idle_q != TMAX) ? idle_q + 1'b1 : idle_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxp_q  <= 1'b1;
            idle_q <= '0;
        end else begin
            rxp_q  <= rxs_q;
            idle_q <= idle_d;
        end
    end
`endif

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        ferr_d  = ferr_q;
        words_d = words_q;
        // Completion lags the final write by one clock, never coinciding with it.
        over_d  = over_q || (words_q == 16'(WORD_COUNT));
`ifdef UART_LOADER_TIMEOUT_EN
        over_d  = over_d || (idle_q == TMAX && words_q != 16'd0);
`endif
        case (st_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) st_d = START;
            end
            START: if (cnt_q == CNT_HALF) begin
                cnt_d = '0;
                bit_d = 3'd0;
                st_d  = rxs_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == CNT_FULL) begin
                cnt_d  = '0;
                byte_d = {rxs_q, byte_q[7:1]};
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = STOP;
            end
            default: if (cnt_q == CNT_FULL) begin
                st_d = IDLE;
                if (!rxs_q) begin
                    ferr_d = 1'b1;
                end else if (idx_q == 2'd3) begin
                    data_d  = {byte_q, shift_q};
                    addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
                    wr_d    = 1'b1;
                    words_d = words_q + 16'd1;
                    idx_d   = 2'd0;
                end else begin
                    shift_d[8*idx_q +: 8] = byte_q;
                    idx_d = idx_q + 2'd1;
                end
            end
        endcase
        if (over_q) st_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            st_q    <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
            data_q  <= 32'd0;
            addr_q  <= BASE_ADDR;
            wr_q    <= 1'b0;
            over_q  <= 1'b0;
            ferr_q  <= 1'b0;
            words_q <= 16'd0;
        end else begin
            meta_q  <= Rx;
            rxs_q   <= meta_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            over_q  <= over_d;
            ferr_q  <= ferr_d;
            words_q <= words_d;
        end
    end

    assign UartData    = data_q;
    assign UartAddress = addr_q;
    assign UartWrite   = wr_q;
    assign UartOver    = over_q;
    assign FrameError  = ferr_q;
    assign WordsLoaded = words_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed bench for uart_program_loader at 16 clocks per bit, two-word image.
module tb_uart_program_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0, reset = 1'b0, Rx = 1'b1;
    logic [31:0] UartData, UartAddress;
    logic        UartWrite, UartOver, FrameError;
    logic [15:0] WordsLoaded;

    int vec = 0, errs = 0;
    int cyc = 0, wn = 0, wcyc = 0, ocyc = -1;
    logic [31:0] wa [32];
    logic [31:0] wd [32];

    uart_program_loader #(
        .CLK_FREQ(1600000), .BAUD(100000), .WORD_COUNT(2),
        .BASE_ADDR(32'h0), .TIMEOUT_CLKS(1000)
    ) dut (
        .clk(clk), .reset(reset), .Rx(Rx),
        .UartData(UartData), .UartAddress(UartAddress), .UartWrite(UartWrite),
        .UartOver(UartOver), .FrameError(FrameError), .WordsLoaded(WordsLoaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (UartWrite) begin
            wa[wn % 32] = UartAddress;
            wd[wn % 32] = UartData;
            wn++;
            wcyc = cyc;
        end
        if (!reset) ocyc = -1;
        else if (UartOver && ocyc < 0) ocyc = cyc;
    end

    task automatic send_bit(input logic v);
        Rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        Rx = 1'b1;
        repeat (stop ? 4 : 2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [82:0] got;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        got = {UartData, UartAddress, UartWrite, UartOver, FrameError, WordsLoaded};
        vec++;
        if (got !== 83'd0) begin
            errs++;
            $display("FAIL reset_values got=%h want=%h", got, 83'd0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load;
        int base;
        base = wn;
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        repeat (10) @(negedge clk);
        vec++; if (wn - base !== 2) begin errs++; $display("FAIL load_writes got=%0d want=2", wn - base); end
        vec++; if (wa[base % 32] !== 32'd0 || wd[base % 32] !== 32'h13) begin
            errs++; $display("FAIL load_w0 got=%h/%h want=0/13", wa[base % 32], wd[base % 32]);
        end
        vec++; if (wa[(base + 1) % 32] !== 32'd4 || wd[(base + 1) % 32] !== 32'h0010_0093) begin
            errs++; $display("FAIL load_w1 got=%h/%h want=4/00100093", wa[(base + 1) % 32], wd[(base + 1) % 32]);
        end
        vec++; if (UartOver !== 1'b1 || ocyc - wcyc !== 1) begin
            errs++; $display("FAIL load_over got=%b lag=%0d want=1 lag=1", UartOver, ocyc - wcyc);
        end
        vec++; if (WordsLoaded !== 16'd2 || FrameError !== 1'b0) begin
            errs++; $display("FAIL load_status got=%0d/%b want=2/0", WordsLoaded, FrameError);
        end
    endtask

    task automatic test_after_over;
        int base;
        base = wn;
        send_word(32'hCAFE_F00D);
        repeat (10) @(negedge clk);
        vec++; if (wn - base !== 0) begin errs++; $display("FAIL over_writes got=%0d want=0", wn - base); end
        vec++; if (UartData !== 32'h0010_0093 || UartAddress !== 32'd4) begin
            errs++; $display("FAIL over_hold got=%h/%h want=00100093/4", UartData, UartAddress);
        end
        vec++; if (WordsLoaded !== 16'd2 || UartOver !== 1'b1 || FrameError !== 1'b0) begin
            errs++; $display("FAIL over_status got=%0d/%b/%b want=2/1/0", WordsLoaded, UartOver, FrameError);
        end
    endtask

    task automatic test_glitch;
        int base;
        base = wn;
        Rx = 1'b0;
        repeat (3) @(negedge clk);
        Rx = 1'b1;
        repeat (40) @(negedge clk);
        vec++; if (wn - base !== 0 || FrameError !== 1'b0 || WordsLoaded !== 16'd0) begin
            errs++; $display("FAIL glitch got=%0d/%b/%0d want=0/0/0", wn - base, FrameError, WordsLoaded);
        end
        send_word(32'h1234_5678);
        repeat (4) @(negedge clk);
        vec++; if (wn - base !== 1 || wd[base % 32] !== 32'h1234_5678 || wa[base % 32] !== 32'd0) begin
            errs++; $display("FAIL glitch_word got=%0d/%h/%h want=1/12345678/0", wn - base, wd[base % 32], wa[base % 32]);
        end
    endtask

    task automatic test_frame;
        int base;
        base = wn;
        send_byte(8'hAA, 1'b0);
        vec++; if (FrameError !== 1'b1 || wn - base !== 0) begin
            errs++; $display("FAIL frame_flag got=%b/%0d want=1/0", FrameError, wn - base);
        end
        send_word(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        vec++; if (wn - base !== 1 || wd[base % 32] !== 32'hDEAD_BEEF || wa[base % 32] !== 32'd0) begin
            errs++; $display("FAIL frame_word got=%0d/%h/%h want=1/deadbeef/0", wn - base, wd[base % 32], wa[base % 32]);
        end
        vec++; if (FrameError !== 1'b1 || WordsLoaded !== 16'd1) begin
            errs++; $display("FAIL frame_status got=%b/%0d want=1/1", FrameError, WordsLoaded);
        end
    endtask

    task automatic test_reset_midload;
        int base;
        logic [82:0] got;
        send_word(32'h0000_0013);
        send_byte(8'h93);
        send_byte(8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        got = {UartData, UartAddress, UartWrite, UartOver, FrameError, WordsLoaded};
        vec++; if (got !== 83'd0) begin errs++; $display("FAIL midload_reset got=%h want=0", got); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        base = wn;
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        repeat (10) @(negedge clk);
        vec++; if (wn - base !== 2 || wa[base % 32] !== 32'd0 || wd[base % 32] !== 32'd1) begin
            errs++; $display("FAIL midload_w0 got=%0d/%h/%h want=2/0/1", wn - base, wa[base % 32], wd[base % 32]);
        end
        vec++; if (wa[(base + 1) % 32] !== 32'd4 || wd[(base + 1) % 32] !== 32'd2 || UartOver !== 1'b1) begin
            errs++; $display("FAIL midload_w1 got=%h/%h/%b want=4/2/1", wa[(base + 1) % 32], wd[(base + 1) % 32], UartOver);
        end
    endtask

`ifdef UART_LOADER_TIMEOUT_EN
    task automatic test_timeout;
        int base, lastc;
        do_reset();
        base = wn;
        send_word(32'h0BAD_F00D);
        send_byte(8'h11);
        send_byte(8'h22);
        lastc = cyc;
        repeat (1100) @(negedge clk);
        vec++; if (wn - base !== 1 || wa[base % 32] !== 32'd0 || wd[base % 32] !== 32'h0BAD_F00D) begin
            errs++; $display("FAIL timeout_write got=%0d/%h/%h want=1/0/0badf00d", wn - base, wa[base % 32], wd[base % 32]);
        end
        vec++; if (UartOver !== 1'b1 || ocyc - lastc < 980 || ocyc - lastc > 1020) begin
            errs++; $display("FAIL timeout_over got=%b delay=%0d want=1 delay~1000", UartOver, ocyc - lastc);
        end
        do_reset();
        repeat (1200) @(negedge clk);
        vec++; if (UartOver !== 1'b0 || WordsLoaded !== 16'd0) begin
            errs++; $display("FAIL timeout_empty got=%b/%0d want=0/0", UartOver, WordsLoaded);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_after_over();
        do_reset();
        test_glitch();
        do_reset();
        test_frame();
        test_reset_midload();
`ifdef UART_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
